// File: rtl/psk8_pkg.sv
// psk8_pkg: shared 8-PSK types, default amplitudes, Gray<->position helpers and constellation lookup
package psk8_pkg;

   typedef logic [2:0]        psk8_sym_t;
   typedef logic signed [4:0] iq5_t;
   typedef enum logic {ST_IDLE, ST_TX} psk8_state_t;

   localparam int AMP_AXIS_DEF = 15;
   localparam int AMP_DIAG_DEF = 11;

   // Gray code -> angular position (0..7 in 45 degree steps); same ordering the RX slicer uses
   function automatic logic [2:0] gray2pos(input psk8_sym_t g);
      logic [2:0] p;
      p[2] = g[2];
      p[1] = g[2] ^ g[1];
      p[0] = p[1] ^ g[0];
      return p;
   endfunction

   function automatic psk8_sym_t pos2gray(input logic [2:0] p);
      return p ^ {1'b0, p[2:1]};
   endfunction

   // Returns {I,Q}; a is the on-axis magnitude, d the per-axis diagonal magnitude
   function automatic logic [9:0] psk8_map(input psk8_sym_t s, input iq5_t a, input iq5_t d);
      iq5_t i;
      iq5_t q;
      i = '0;
      q = '0;
      case (gray2pos(s))
         3'd0: begin i = a;  q = '0; end
         3'd1: begin i = d;  q = d;  end
         3'd2: begin i = '0; q = a;  end
         3'd3: begin i = -d; q = d;  end
         3'd4: begin i = -a; q = '0; end
         3'd5: begin i = -d; q = -d; end
         3'd6: begin i = '0; q = -a; end
         default: begin i = d; q = -d; end
      endcase
      return {i, q};
   endfunction

endpackage

// File: rtl/psk8_if.sv
// psk8_if: byte-stream valid/ready handshake into the 8-PSK modulator
interface psk8_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   modport master (output s_data, s_valid, s_last, input s_ready);
   modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/psk8_bit_packer.sv
// psk8_bit_packer: 10-bit MSB-aligned bit buffer turning bytes into 3-bit symbols, with end-of-frame padding
module psk8_bit_packer
   import psk8_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   psk8_if.slave     s,
   input  logic      sym_pop,
   output logic      sym_avail,
   output psk8_sym_t sym_data,
   output logic      buf_nonempty
);

   logic [9:0] r_buf;
   logic [3:0] r_bcnt;
   logic       r_last_pend;
   logic       w_accept;
   logic [3:0] w_pcnt;
   logic [9:0] w_pbuf;

   // Valid bits sit at the top of r_buf with zeros below, so a short final symbol is zero-padded for free
   assign s.s_ready    = (r_bcnt <= 4'd2) && !r_last_pend;
   assign w_accept     = s.s_valid && s.s_ready;
   assign sym_avail    = (r_bcnt >= 4'd3) || (r_last_pend && r_bcnt != 4'd0);
   assign sym_data     = r_buf[9:7];
   assign buf_nonempty = r_bcnt != 4'd0;
   assign w_pcnt       = sym_pop ? (r_bcnt >= 4'd3 ? r_bcnt - 4'd3 : 4'd0) : r_bcnt;
   assign w_pbuf       = sym_pop ? r_buf << 3 : r_buf;

   // Pop first, then append the accepted byte directly below the surviving bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf       <= '0;
         r_bcnt      <= '0;
         r_last_pend <= 1'b0;
      end else begin
         r_buf       <= w_accept ? (w_pbuf | ({s.s_data, 2'b00} >> w_pcnt)) : w_pbuf;
         r_bcnt      <= w_accept ? w_pcnt + 4'd8 : w_pcnt;
         r_last_pend <= (w_accept && s.s_last) || (r_last_pend && w_pcnt != 4'd0);
      end
   end

endmodule

// File: rtl/psk8_modulator.sv
// psk8_modulator: 8-PSK TX mapper (bytes -> Gray 8-PSK I/Q, SPS clocks per symbol); PSK8_DIFF_EN enables differential encoding
module psk8_modulator
   import psk8_pkg::*;
#(
   parameter int SPS      = 4,
   parameter int AMP_AXIS = AMP_AXIS_DEF,
   parameter int AMP_DIAG = AMP_DIAG_DEF
) (
   input  logic      clk,
   input  logic      rst_n,
   psk8_if.slave     s,
   output iq5_t      i_out,
   output iq5_t      q_out,
   output psk8_sym_t sym_out,
   output logic      out_valid,
   output logic      sym_strobe,
   output logic      busy
);

   psk8_state_t r_state, w_state_nx;
   logic [5:0]  r_cnt, w_cnt_nx;
   psk8_sym_t   r_sym, w_sym_nx, w_tx_sym, w_sym_data;
   logic        r_act, w_act_nx, r_first, w_first_nx;
   logic        w_sym_avail, w_pop, w_slot_free, w_buf_nonempty;
   iq5_t        w_i, w_q;

   psk8_bit_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .s            (s),
      .sym_pop      (w_pop),
      .sym_avail    (w_sym_avail),
      .sym_data     (w_sym_data),
      .buf_nonempty (w_buf_nonempty)
   );

   assign w_slot_free = (r_state == ST_IDLE) || (r_cnt == 6'(SPS - 1));
   assign w_pop       = w_slot_free && w_sym_avail;
   assign busy        = w_buf_nonempty || (r_state == ST_TX);

`ifdef PSK8_DIFF_EN
   logic [2:0] r_phase, w_phase_sum, w_phase_nx;
   assign w_phase_sum = r_phase + gray2pos(w_sym_data);
   assign w_tx_sym    = pos2gray(w_phase_sum);
   assign w_phase_nx  = w_pop ? w_phase_sum : (w_state_nx == ST_IDLE ? 3'd0 : r_phase);

   // Phase accumulator; restarts from 0 whenever the transmitter goes idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_phase <= '0;
      else        r_phase <= w_phase_nx;
   end
`else
   assign w_tx_sym = w_sym_data;
`endif

   // Next state: load a symbol whenever the slot is free, otherwise hold or fall back to idle
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 6'd1;
      w_sym_nx   = r_sym;
      w_act_nx   = r_act;
      w_first_nx = 1'b0;
      if (w_pop) begin
         w_state_nx = ST_TX;
         w_cnt_nx   = '0;
         w_sym_nx   = w_tx_sym;
         w_act_nx   = 1'b1;
         w_first_nx = 1'b1;
      end else if (w_slot_free) begin
         w_state_nx = ST_IDLE;
         w_cnt_nx   = '0;
         w_sym_nx   = '0;
         w_act_nx   = 1'b0;
      end
   end

   // FSM state and symbol registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sym   <= '0;
         r_act   <= 1'b0;
         r_first <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_sym   <= w_sym_nx;
         r_act   <= w_act_nx;
         r_first <= w_first_nx;
      end
   end

   assign {w_i, w_q} = psk8_map(r_sym, iq5_t'(AMP_AXIS), iq5_t'(AMP_DIAG));

   // Registered output stage driving the DAC path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_out      <= '0;
         q_out      <= '0;
         sym_out    <= '0;
         out_valid  <= 1'b0;
         sym_strobe <= 1'b0;
      end else begin
         i_out      <= r_act ? w_i : '0;
         q_out      <= r_act ? w_q : '0;
         sym_out    <= r_sym;
         out_valid  <= r_act;
         sym_strobe <= r_first;
      end
   end

endmodule
